motor_ramp: RTL and testbench
=============================

# motor_ramp

Slew-rate limiter that sits directly upstream of the motor controller. It accepts signed left/right wheel drive targets from the steering/command logic over a valid/ready handshake. It moves its registered `lft`/`rht` outputs toward those targets by a bounded step once per ramp tick, which gives soft starts and soft direction reversals without current spikes. It also provides a one-cycle emergency stop that overrides any ramp in progress.

## Interface
- `STEP`, default 16: magnitude added or removed per axis per ramp tick; legal range 1..1023.
- `TICK_DIV`, default 1024: clock cycles per ramp tick; must be ≥ 2.
- `clk`  in  1  system clock; all logic runs on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_vld`  in  1  upstream target pair valid.
- `cmd_rdy`  out  1  target accepted when `cmd_vld & cmd_rdy` is high at a rising edge.
- `cmd_lft`  in  11  signed left-wheel target.
- `cmd_rht`  in  11  signed right-wheel target.
- `estop`  in  1  level-sensitive emergency stop.
- `lft`  out  11  signed registered left-wheel drive; goes to the motor controller.
- `rht`  out  11  signed registered right-wheel drive; goes to the motor controller.
- `busy`  out  1  high while either axis has not yet reached its target.

## Operation
- **States:**
  - IDLE: both axes at target.
  - RAMP: at least one axis short of its target.
  - ESTOP: emergency stop in force.
- **Reset:**
  - `lft`, `rht`, both targets and the tick counter clear to 0.
  - State goes to IDLE; `busy` = 0.
  - `cmd_rdy` = 0 while `rst` is high.
- **Ready:** `cmd_rdy` = !rst & !estop & (state != ESTOP). This is combinational and introduces no bubble.
- **Target saturation:**
  - Each accepted target is clamped to [-1023, +1023].
  - -1024 is stored as -1023, so the downstream 10-bit magnitude never overflows.
- **Accept in IDLE:**
  - Targets are latched and the tick counter clears to 0.
  - The block goes to RAMP if either saturated target differs from its output; otherwise it stays in IDLE.
- **Accept in RAMP:**
  - The targets are overwritten.
  - The tick counter is not cleared, so the cadence is preserved.
- **Step rule, per axis, on each tick:**
  - Compute diff = tgt − cur at 12-bit signed width.
  - If |diff| ≤ STEP, then cur = tgt.
  - Otherwise cur = cur + STEP·sign(diff).
  - A reversal passes through 0 as an ordinary value, with no special dwell.
- **RAMP to IDLE:** taken on the tick after which both axes equal their targets. `busy` = (state == RAMP).
- **ESTOP entry:**
  - `estop` high in any state moves to ESTOP on the next edge.
  - `lft`, `rht` and both targets clear to 0 on that same edge.
- **ESTOP exit:** when `estop` is sampled low, the block returns to IDLE. It does not resume the old target.
- **Simultaneous `estop` and `cmd_vld`:** `estop` wins and the command is not accepted.

## Timing
- Outputs are registered.
- Acceptance to first output change: exactly TICK_DIV cycles, when accepted from IDLE.
- The tick fires when the counter equals TICK_DIV−1; the counter then wraps to 0.
- The counter runs only in RAMP. It holds at 0 in IDLE and ESTOP.
- Full-scale swing from −1023 to +1023 takes ceil(2046/STEP) ticks.
- `estop` to outputs at 0: 1 cycle.
- Reset mid-ramp: outputs are 0 on the first edge with `rst` high.

## Structure
- Shared package `motor_pkg`:
  - `MAG_MAX = 1023`.
  - State enum `ramp_state_t` {IDLE, RAMP, ESTOP}.
  - Drive-word typedef `drive_t` = logic signed [10:0].
- Sub-module `ramp_axis`:
  - Holds one axis's target register, saturation, step arithmetic and `at_tgt` flag.
  - Instantiated twice.
- The top level holds the FSM, the tick counter and the handshake.

## Test plan
Bench parameters: STEP=16, TICK_DIV=4.
- **Reset:** hold `rst` for 3 cycles, then release. Required: `lft`=`rht`=0, `busy`=0, `cmd_rdy`=0 during reset and 1 after.
- **Basic ramp:** accept `cmd_lft`=100, `cmd_rht`=−50.
  - `lft` must go 16, 32, 48, 64, 80, 96, 100, changing every 4 cycles, first change 4 cycles after acceptance.
  - `rht` must go −16, −32, −48, −50.
  - `busy` must fall after the tick on which `lft` reaches 100.
- **Saturation:** accept `cmd_lft`=−1024 from `lft`=−1016. Required: `lft` = −1023 after one tick, never −1024.
- **Mid-ramp retarget:** with `lft`=48 ramping toward 100, accept `cmd_lft`=0. Required: next tick gives 32, then 16, then 0, with no reset of tick cadence.
- **ESTOP:** assert `estop` with `lft`=64, while `cmd_vld` is also high. Required:
  - `lft`=`rht`=0 next cycle; `cmd_rdy`=0; the command is ignored.
  - After `estop` falls: state IDLE, targets 0, `busy`=0.
- **Reversal:** from `lft`=8, accept `cmd_lft`=−20. Required: `lft` goes −8, then −20, passing through sign change with no dwell.

Source files
------------

// File: rtl/motor_ramp_pkg.sv
// Shared types and constants for the motor slew-rate limiter.
package motor_pkg;

    // Largest drive magnitude the motor controller accepts on either axis.
    localparam int MAG_MAX = 1023;

    // Signed drive word used for targets and outputs.
    typedef logic signed [10:0] drive_t;

    // Only the most negative code lies outside [-MAG_MAX, +MAG_MAX].
    localparam drive_t DRIVE_OVF = 11'sh400;
    localparam drive_t DRIVE_MIN = -11'sd1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        ESTOP = 2'd2
    } ramp_state_t;

    // Fold -1024 onto -1023 so the downstream 10-bit magnitude cannot overflow.
    function automatic drive_t sat_drive(input drive_t value);
        return (value == DRIVE_OVF) ? DRIVE_MIN : value;
    endfunction

endpackage

// File: rtl/motor_ramp_if.sv
// Target command channel: upstream steering logic hands over a left/right pair.
interface motor_ramp_if;
    import motor_pkg::*;

    logic   cmd_vld;
    logic   cmd_rdy;
    drive_t cmd_lft;
    drive_t cmd_rht;

    modport master (
        output cmd_vld,
        output cmd_lft,
        output cmd_rht,
        input  cmd_rdy
    );

    modport slave (
        input  cmd_vld,
        input  cmd_lft,
        input  cmd_rht,
        output cmd_rdy
    );

endinterface

// File: rtl/motor_ramp_axis.sv
// One wheel axis: target register, saturation and bounded-step arithmetic.
module ramp_axis
    import motor_pkg::*;
#(
    parameter int STEP = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr_i,        // emergency stop: drop target and output to 0
    input  logic   load_i,       // latch a new target from cmd_i
    input  logic   tick_i,       // apply one step toward the target
    input  drive_t cmd_i,
    output drive_t cur_o,
    output logic   at_tgt_o,     // the next tick lands this axis on its target
    output logic   cmd_moves_o   // the offered command differs from the output
);

    localparam drive_t      STEP_W   = drive_t'(STEP);
    localparam logic [11:0] STEP_MAG = 12'(STEP);

    drive_t tgt_q, tgt_d;
    drive_t cur_q, cur_d;
    drive_t cmd_sat;
    drive_t stepped;

    logic signed [11:0] diff;
    logic [11:0]        mag;
    logic               step_done;

    // Step arithmetic: 12-bit difference so a full -1023..+1023 swing cannot wrap.
    always_comb begin
        cmd_sat   = sat_drive(cmd_i);
        diff      = {tgt_q[10], tgt_q} - {cur_q[10], cur_q};
        mag       = diff[11] ? 12'(-diff) : 12'(diff);
        step_done = (mag <= STEP_MAG);
        if (step_done) begin
            stepped = tgt_q;
        end else if (diff[11]) begin
            stepped = cur_q - STEP_W;
        end else begin
            stepped = cur_q + STEP_W;
        end
    end

    // Next-state for target and output; estop clear dominates load and tick.
    always_comb begin
        tgt_d = tgt_q;
        cur_d = cur_q;
        if (clr_i) begin
            tgt_d = '0;
            cur_d = '0;
        end else begin
            if (load_i) begin
                tgt_d = cmd_sat;
            end
            if (tick_i) begin
                cur_d = stepped;
            end
        end
    end

    // Axis registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q <= '0;
            cur_q <= '0;
        end else begin
            tgt_q <= tgt_d;
            cur_q <= cur_d;
        end
    end

    assign cur_o       = cur_q;
    assign at_tgt_o    = step_done;
    assign cmd_moves_o = (cmd_sat != cur_q);

endmodule

// File: rtl/motor_ramp.sv
// Slew-rate limiter in front of the motor controller: FSM, tick counter, handshake.
module motor_ramp
    import motor_pkg::*;
#(
    parameter int STEP     = 16,
    parameter int TICK_DIV = 1024
) (
    input  logic         clk,
    input  logic         rst,
    motor_ramp_if.slave  cmd,
    input  logic         estop,
    output drive_t       lft,
    output drive_t       rht,
    output logic         busy
);

    localparam int             N_AXIS   = 2;
    localparam int             CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    ramp_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rdy;
    logic accept;
    logic tick;
    logic load;

    drive_t              cmd_arr [N_AXIS];
    drive_t              cur_arr [N_AXIS];
    logic [N_AXIS-1:0]   at_tgt;
    logic [N_AXIS-1:0]   cmd_moves;

    assign cmd_arr[0] = cmd.cmd_lft;
    assign cmd_arr[1] = cmd.cmd_rht;

    // Left and right axes share every control strobe.
    for (genvar gi = 0; gi < N_AXIS; gi++) begin : g_axis
        ramp_axis #(
            .STEP (STEP)
        ) u_axis (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (estop),
            .load_i      (load),
            .tick_i      (tick),
            .cmd_i       (cmd_arr[gi]),
            .cur_o       (cur_arr[gi]),
            .at_tgt_o    (at_tgt[gi]),
            .cmd_moves_o (cmd_moves[gi])
        );
    end

    assign accept = cmd.cmd_vld && rdy;
    assign load   = accept;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; estop overrides everything.
    always_comb begin
        state_d = state_q;
        if (estop) begin
            state_d = ESTOP;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && (|cmd_moves)) begin
                        state_d = RAMP;
                    end
                end
                RAMP: begin
                    // A target arriving on the exit tick keeps us ramping; the next
                    // tick re-evaluates against the new target.
                    if (tick && (&at_tgt) && !accept) begin
                        state_d = IDLE;
                    end
                end
                ESTOP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM outputs: handshake ready, busy flag and the ramp tick strobe.
    always_comb begin
        rdy  = !rst && !estop && (state_q != ESTOP);
        busy = (state_q == RAMP);
        tick = (state_q == RAMP) && (cnt_q == CNT_LAST);
    end

    // Tick counter runs only while ramping; retargets in RAMP keep the cadence.
    always_comb begin
        cnt_d = '0;
        if ((state_q == RAMP) && !estop && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Tick counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cmd.cmd_rdy = rdy;
    assign lft         = cur_arr[0];
    assign rht         = cur_arr[1];

endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp with STEP=16, TICK_DIV=4.
module tb_motor_ramp;
    import motor_pkg::*;

    logic   clk;
    logic   rst;
    logic   estop;
    drive_t lft;
    drive_t rht;
    logic   busy;

    int vectors;
    int miscompares;

    motor_ramp_if cmd_if ();

    motor_ramp #(
        .STEP     (16),
        .TICK_DIV (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cmd_if),
        .estop (estop),
        .lft   (lft),
        .rht   (rht),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int l, input int r);
        cmd_if.cmd_vld = 1'b1;
        cmd_if.cmd_lft = 11'(l);
        cmd_if.cmd_rht = 11'(r);
        #1;
        chk("rdy_at_accept", int'(cmd_if.cmd_rdy), 1);
        cyc();
        cmd_if.cmd_vld = 1'b0;
    endtask

    // Three quiet cycles holding the previous value, then the tick edge.
    task automatic ramp_tick(input int pl, input int el, input int er, input int eb);
        repeat (3) cyc();
        chk("lft_hold", int'(lft), pl);
        cyc();
        chk("lft_tick", int'(lft), el);
        chk("rht_tick", int'(rht), er);
        chk("busy_tick", int'(busy), eb);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy) break;
            cyc();
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        estop          = 1'b0;
        cmd_if.cmd_vld = 1'b0;
        cmd_if.cmd_lft = '0;
        cmd_if.cmd_rht = '0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_lft", int'(lft), 0);
            chk("rst_rht", int'(rht), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_rdy", int'(cmd_if.cmd_rdy), 0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", int'(cmd_if.cmd_rdy), 1);
        cyc();
        chk("post_rst_busy", int'(busy), 0);

        // Basic ramp 100 / -50.
        accept(100, -50);
        chk("basic_busy", int'(busy), 1);
        chk("basic_lft0", int'(lft), 0);
        ramp_tick(0,   16,  -16, 1);
        ramp_tick(16,  32,  -32, 1);
        ramp_tick(32,  48,  -48, 1);
        ramp_tick(48,  64,  -50, 1);
        ramp_tick(64,  80,  -50, 1);
        ramp_tick(80,  96,  -50, 1);
        ramp_tick(96, 100,  -50, 0);

        // Saturation: -1024 lands on -1023.
        accept(-1016, -50);
        wait_idle(2000);
        chk("sat_pre", int'(lft), -1016);
        accept(-1024, -50);
        ramp_tick(-1016, -1023, -50, 0);
        repeat (8) cyc();
        chk("sat_hold", int'(lft), -1023);

        // Return both axes to 0.
        accept(0, 0);
        wait_idle(2000);
        chk("zero_lft", int'(lft), 0);
        chk("zero_rht", int'(rht), 0);

        // Mid-ramp retarget keeps the tick cadence.
        accept(100, 0);
        ramp_tick(0,  16, 0, 1);
        ramp_tick(16, 32, 0, 1);
        ramp_tick(32, 48, 0, 1);
        cmd_if.cmd_vld = 1'b1;
        cmd_if.cmd_lft = 11'(0);
        cmd_if.cmd_rht = 11'(0);
        cyc();
        cmd_if.cmd_vld = 1'b0;
        chk("retgt_busy", int'(busy), 1);
        repeat (2) cyc();
        chk("retgt_hold", int'(lft), 48);
        cyc();
        chk("retgt_t1", int'(lft), 32);
        ramp_tick(32, 16, 0, 1);
        ramp_tick(16, 0,  0, 0);

        // ESTOP at lft=64 with a command offered at the same time.
        accept(100, 0);
        ramp_tick(0,  16, 0, 1);
        ramp_tick(16, 32, 0, 1);
        ramp_tick(32, 48, 0, 1);
        ramp_tick(48, 64, 0, 1);
        estop          = 1'b1;
        cmd_if.cmd_vld = 1'b1;
        cmd_if.cmd_lft = 11'(500);
        cmd_if.cmd_rht = 11'(-500);
        #1;
        chk("estop_rdy_now", int'(cmd_if.cmd_rdy), 0);
        cyc();
        chk("estop_lft", int'(lft), 0);
        chk("estop_rht", int'(rht), 0);
        chk("estop_busy", int'(busy), 0);
        chk("estop_rdy", int'(cmd_if.cmd_rdy), 0);
        cyc();
        chk("estop_lft_hold", int'(lft), 0);
        estop          = 1'b0;
        cmd_if.cmd_vld = 1'b0;
        #1;
        chk("estop_exit_rdy_low", int'(cmd_if.cmd_rdy), 0);
        cyc();
        chk("estop_exit_busy", int'(busy), 0);
        chk("estop_exit_rdy", int'(cmd_if.cmd_rdy), 1);
        repeat (8) cyc();
        chk("estop_no_resume_lft", int'(lft), 0);
        chk("estop_no_resume_rht", int'(rht), 0);
        chk("estop_no_resume_busy", int'(busy), 0);

        // Reversal through zero with no dwell.
        accept(8, 0);
        ramp_tick(0, 8, 0, 0);
        accept(-20, 0);
        ramp_tick(8,  -8,  0, 1);
        ramp_tick(-8, -20, 0, 0);

        // Reset in the middle of a ramp.
        accept(100, 0);
        ramp_tick(-20, -4, 0, 1);
        cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_lft", int'(lft), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rdy", int'(cmd_if.cmd_rdy), 0);
        rst = 1'b0;
        repeat (6) cyc();
        chk("midrst_after_lft", int'(lft), 0);
        chk("midrst_after_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
